// File: rtl/nibble_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_bus_pkg
//  Description : Shared definitions for the nibble bus target. Holds the
//                peripheral register offsets, the CTRL/STAT bit positions and
//                the timer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package nibble_bus_pkg;

    // Register offsets within the 16-entry peripheral page
    localparam logic [3:0] OFF_GPIO_OUT_L = 4'h0;
    localparam logic [3:0] OFF_GPIO_OUT_H = 4'h1;
    localparam logic [3:0] OFF_GPIO_IN_L  = 4'h2;
    localparam logic [3:0] OFF_GPIO_IN_H  = 4'h3;
    localparam logic [3:0] OFF_CTRL       = 4'h4;
    localparam logic [3:0] OFF_STAT       = 4'h5;
    localparam logic [3:0] OFF_CMP_L      = 4'h6;
    localparam logic [3:0] OFF_CMP_H      = 4'h7;
    localparam logic [3:0] OFF_CNT_L      = 4'h8;
    localparam logic [3:0] OFF_CNT_H      = 4'h9;
    localparam logic [3:0] OFF_PRESCALE   = 4'hA;

    // CTRL register bits
    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STAT register bits
    localparam int STAT_MATCH  = 0;

    // Timer state machine
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } timer_state_e;

endpackage
`default_nettype wire

// File: rtl/nibble_timer.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_timer
//  Description : 8-bit prescaled timer with compare, one-shot/reload modes,
//                sticky match flag and registered level interrupt. Register
//                write strobes and nibble data come from the bus decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_timer
    import nibble_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ctrl_we,
    input  logic       i_stat_we,
    input  logic       i_cmp_lo_we,
    input  logic       i_cmp_hi_we,
    input  logic       i_cnt_we,
    input  logic       i_presc_we,
    input  logic [3:0] i_wdata,
    output logic [2:0] o_ctrl,
    output logic       o_match,
    output logic [7:0] o_compare,
    output logic [7:0] o_count,
    output logic [3:0] o_presc_exp,
    output logic       o_irq
);

    timer_state_e r_state;
    logic [2:0]   r_ctrl;
    logic         r_match;
    logic         r_irq;
    logic [7:0]   r_cmp;
    logic [7:0]   r_count;
    logic [3:0]   r_presc_exp;
    logic [15:0]  r_presc;

    logic         w_en_next;
    logic [15:0]  w_presc_term;
    logic         w_tick;

    // The enable the timer will see after this edge; a CTRL write clearing
    // en must discard a tick on the same edge, so look ahead at the write.
    assign w_en_next    = i_ctrl_we ? i_wdata[CTRL_EN] : r_ctrl[CTRL_EN];
    assign w_presc_term = (16'd1 << r_presc_exp) - 16'd1;
    // ">=" so that lowering the exponent mid-run cannot strand the prescaler
    // above the new terminal value.
    assign w_tick       = (r_presc >= w_presc_term);

    // Register file, prescaler, count FSM, match flag and interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ctrl      <= 3'b000;
            r_match     <= 1'b0;
            r_irq       <= 1'b0;
            r_cmp       <= 8'h00;
            r_count     <= 8'h00;
            r_presc_exp <= 4'h0;
            r_presc     <= 16'h0000;
        end else begin
            if (i_ctrl_we)   r_ctrl      <= i_wdata[2:0];
            if (i_cmp_lo_we) r_cmp[3:0]  <= i_wdata;
            if (i_cmp_hi_we) r_cmp[7:4]  <= i_wdata;
            if (i_presc_we)  r_presc_exp <= i_wdata;

            r_irq <= r_match & r_ctrl[CTRL_IRQ_EN];

            // Clear first; a match set below on the same edge overrides it
            if (i_stat_we && i_wdata[STAT_MATCH]) r_match <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_presc <= 16'h0000;
                    if (i_cnt_we)  r_count <= 8'h00;
                    if (w_en_next) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!w_en_next) begin
                        r_state <= ST_IDLE;
                        r_presc <= 16'h0000;
                        if (i_cnt_we) r_count <= 8'h00;
                    end else if (i_cnt_we) begin
                        // A count write beats a coincident tick
                        r_count <= 8'h00;
                        r_presc <= 16'h0000;
                    end else if (w_tick) begin
                        r_presc <= 16'h0000;
                        if (r_count == r_cmp) begin
                            r_match <= 1'b1;
                            if (r_ctrl[CTRL_RELOAD]) r_count <= 8'h00;
                            else                     r_state <= ST_HALT;
                        end else begin
                            r_count <= r_count + 8'd1;
                        end
                    end else begin
                        r_presc <= r_presc + 16'd1;
                    end
                end
                ST_HALT: begin
                    r_presc <= 16'h0000;
                    if (i_cnt_we) r_count <= 8'h00;
                    if (!w_en_next)    r_state <= ST_IDLE;
                    else if (i_cnt_we) r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_presc <= 16'h0000;
                end
            endcase
        end
    end

    assign o_ctrl      = r_ctrl;
    assign o_match     = r_match;
    assign o_compare   = r_cmp;
    assign o_count     = r_count;
    assign o_presc_exp = r_presc_exp;
    assign o_irq       = r_irq;

endmodule
`default_nettype wire

// File: rtl/nibble_bus_target.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_bus_target
//  Description : Target side of the CPU's 4-bit data / 12-bit address bus.
//                Decodes scratch RAM, GPIO and timer registers; reads are
//                combinational, writes commit on the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_bus_target
    import nibble_bus_pkg::*;
#(
    parameter int          RAM_DEPTH   = 16,
    parameter logic [11:0] PERIPH_BASE = 12'hF00
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bus_addr,
    input  logic        bus_data_rw,
    input  logic [3:0]  bus_data_in,
    output logic [3:0]  bus_data_out,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic        irq
);

    localparam int AW = $clog2(RAM_DEPTH);

    logic [3:0]    r_ram [RAM_DEPTH];
    logic [7:0]    r_gpio_out;
    logic [7:0]    r_gpio_s1;
    logic [7:0]    r_gpio_s2;

    logic          w_ram_hit;
    logic [AW-1:0] w_ram_idx;
    logic          w_periph_hit;
    logic [3:0]    w_off;
    logic          w_pwr;
    logic [3:0]    w_rdata;

    logic [2:0]    w_ctrl;
    logic          w_match;
    logic [7:0]    w_compare;
    logic [7:0]    w_count;
    logic [3:0]    w_presc_exp;

    // The peripheral page is assumed 16-aligned, so the low nibble is the offset
    assign w_ram_hit    = (bus_addr < 12'(RAM_DEPTH));
    assign w_ram_idx    = bus_addr[AW-1:0];
    assign w_periph_hit = (bus_addr[11:4] == PERIPH_BASE[11:4]);
    assign w_off        = bus_addr[3:0];
    assign w_pwr        = bus_data_rw & w_periph_hit;

    // Scratch RAM write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_DEPTH; i++) r_ram[i] <= 4'h0;
        end else if (bus_data_rw && w_ram_hit) begin
            r_ram[w_ram_idx] <= bus_data_in;
        end
    end

    // GPIO output register, written a nibble at a time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gpio_out <= 8'h00;
        end else if (w_pwr) begin
            if (w_off == OFF_GPIO_OUT_L) r_gpio_out[3:0] <= bus_data_in;
            if (w_off == OFF_GPIO_OUT_H) r_gpio_out[7:4] <= bus_data_in;
        end
    end

    // Two-flop synchronizer for the asynchronous GPIO inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gpio_s1 <= 8'h00;
            r_gpio_s2 <= 8'h00;
        end else begin
            r_gpio_s1 <= gpio_in;
            r_gpio_s2 <= r_gpio_s1;
        end
    end

    nibble_timer u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ctrl_we   (w_pwr && (w_off == OFF_CTRL)),
        .i_stat_we   (w_pwr && (w_off == OFF_STAT)),
        .i_cmp_lo_we (w_pwr && (w_off == OFF_CMP_L)),
        .i_cmp_hi_we (w_pwr && (w_off == OFF_CMP_H)),
        .i_cnt_we    (w_pwr && ((w_off == OFF_CNT_L) || (w_off == OFF_CNT_H))),
        .i_presc_we  (w_pwr && (w_off == OFF_PRESCALE)),
        .i_wdata     (bus_data_in),
        .o_ctrl      (w_ctrl),
        .o_match     (w_match),
        .o_compare   (w_compare),
        .o_count     (w_count),
        .o_presc_exp (w_presc_exp),
        .o_irq       (irq)
    );

    // Zero-latency read mux; unmapped addresses read as zero
    always_comb begin
        w_rdata = 4'h0;
        if (w_ram_hit) begin
            w_rdata = r_ram[w_ram_idx];
        end else if (w_periph_hit) begin
            case (w_off)
                OFF_GPIO_OUT_L: w_rdata = r_gpio_out[3:0];
                OFF_GPIO_OUT_H: w_rdata = r_gpio_out[7:4];
                OFF_GPIO_IN_L:  w_rdata = r_gpio_s2[3:0];
                OFF_GPIO_IN_H:  w_rdata = r_gpio_s2[7:4];
                OFF_CTRL:       w_rdata = {1'b0, w_ctrl};
                OFF_STAT:       w_rdata = {3'b000, w_match};
                OFF_CMP_L:      w_rdata = w_compare[3:0];
                OFF_CMP_H:      w_rdata = w_compare[7:4];
                OFF_CNT_L:      w_rdata = w_count[3:0];
                OFF_CNT_H:      w_rdata = w_count[7:4];
                OFF_PRESCALE:   w_rdata = w_presc_exp;
                default:        w_rdata = 4'h0;
            endcase
        end
    end

    assign bus_data_out = w_rdata;
    assign gpio_out     = r_gpio_out;

endmodule
`default_nettype wire

// File: tb/tb_nibble_bus_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_bus_target
//  Description : Self-checking bench for nibble_bus_target: directed scenarios
//                followed by random bus traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_bus_target;

    localparam logic [11:0] BASE = 12'hF00;
    localparam int          RD   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] bus_addr;
    logic        bus_data_rw;
    logic [3:0]  bus_data_in;
    logic [3:0]  bus_data_out;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tb_gin = 8'h00;
    logic [3:0] last_rd;
    logic [7:0] last_gpio;
    logic       last_irq;

    always #5 clk = ~clk;

    nibble_bus_target #(.RAM_DEPTH(16), .PERIPH_BASE(BASE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_addr     (bus_addr),
        .bus_data_rw  (bus_data_rw),
        .bus_data_in  (bus_data_in),
        .bus_data_out (bus_data_out),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .irq          (irq)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] m_ram [RD];
    logic [7:0] m_gpio, m_s1, m_s2, m_cmp, m_cnt;
    bit         m_en, m_rel, m_ien, m_match, m_irq, m_halted;
    int         m_p, m_presc;

    function automatic void m_reset();
        for (int i = 0; i < RD; i++) m_ram[i] = 4'h0;
        m_gpio = 8'h00; m_s1 = 8'h00; m_s2 = 8'h00; m_cmp = 8'h00; m_cnt = 8'h00;
        m_en = 0; m_rel = 0; m_ien = 0; m_match = 0; m_irq = 0; m_halted = 0;
        m_p = 0; m_presc = 0;
    endfunction

    function automatic logic [3:0] m_read(input logic [11:0] a);
        int off;
        if (int'(a) < RD) return m_ram[a[3:0]];
        off = int'(a) - int'(BASE);
        case (off)
            0:  return m_gpio[3:0];
            1:  return m_gpio[7:4];
            2:  return m_s2[3:0];
            3:  return m_s2[7:4];
            4:  return {1'b0, m_ien, m_rel, m_en};
            5:  return {3'b000, m_match};
            6:  return m_cmp[3:0];
            7:  return m_cmp[7:4];
            8:  return m_cnt[3:0];
            9:  return m_cnt[7:4];
            10: return 4'(m_p);
            default: return 4'h0;
        endcase
    endfunction

    function automatic bit m_will_tick();
        return m_en && !m_halted && (m_presc >= ((1 << m_p) - 1));
    endfunction

    // One clock edge of the whole target, given the bus cycle presented
    function automatic void m_step(input logic [11:0] a, input bit rw,
                                   input logic [3:0] d, input logic [7:0] gin);
        int off;
        bit ctrl_w, stat_w, cnt_w, new_en, nmatch;
        off    = int'(a) - int'(BASE);
        ctrl_w = rw && (off == 4);
        stat_w = rw && (off == 5);
        cnt_w  = rw && (off == 8 || off == 9);
        new_en = ctrl_w ? d[0] : m_en;
        m_irq  = m_match && m_ien;
        nmatch = m_match;
        if (stat_w && d[0]) nmatch = 0;
        if (!new_en) begin
            m_halted = 0; m_presc = 0;
            if (cnt_w) m_cnt = 8'h00;
        end else if (cnt_w) begin
            m_cnt = 8'h00; m_presc = 0; m_halted = 0;
        end else if (!m_en || m_halted) begin
            m_presc = 0;
        end else if (m_will_tick()) begin
            m_presc = 0;
            if (m_cnt == m_cmp) begin
                nmatch = 1;
                if (m_rel) m_cnt = 8'h00;
                else       m_halted = 1;
            end else begin
                m_cnt = m_cnt + 8'd1;
            end
        end else begin
            m_presc++;
        end
        m_match = nmatch;
        if (rw) begin
            if (int'(a) < RD) m_ram[a[3:0]] = d;
            else case (off)
                0:  m_gpio[3:0] = d;
                1:  m_gpio[7:4] = d;
                4:  begin m_en = d[0]; m_rel = d[1]; m_ien = d[2]; end
                6:  m_cmp[3:0] = d;
                7:  m_cmp[7:4] = d;
                10: m_p = int'(d);
                default: ;
            endcase
        end
        m_s2 = m_s1;
        m_s1 = gin;
    endfunction

    // One bus cycle: drive at negedge, check outputs, advance model at posedge
    task automatic cyc(input logic [11:0] a, input bit rw, input logic [3:0] d);
        @(negedge clk);
        bus_addr = a; bus_data_rw = rw; bus_data_in = d; gpio_in = tb_gin;
        #1;
        last_rd = bus_data_out; last_gpio = gpio_out; last_irq = irq;
        chk("rdata", 16'(bus_data_out), 16'(m_read(a)));
        chk("gpio_out", 16'(gpio_out), 16'(m_gpio));
        chk("irq", 16'(irq), 16'(m_irq));
        @(posedge clk);
        m_step(a, rw, d, gpio_in);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits[$];
        bit done;
        logic [11:0] a;
        logic [3:0]  d;
        bit          rw;

        rst_n = 1'b0; bus_addr = 12'h000; bus_data_rw = 1'b0; bus_data_in = 4'h0; gpio_in = 8'h00;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        // Reset state
        cyc(12'h000, 0, 4'h0);      chk("rst_ram0", 16'(last_rd), 16'h0);
        cyc(BASE, 0, 4'h0);         chk("rst_gpio_l", 16'(last_rd), 16'h0);
        cyc(BASE + 12'd5, 0, 4'h0); chk("rst_stat", 16'(last_rd), 16'h0);
        chk("rst_gpio_out", 16'(last_gpio), 16'h0);
        chk("rst_irq", 16'(last_irq), 16'h0);

        // RAM and unmapped space
        cyc(12'h003, 1, 4'hA);
        cyc(12'h003, 0, 4'h0);      chk("ram_wr_rd", 16'(last_rd), 16'hA);
        cyc(12'h400, 1, 4'hF);
        cyc(12'h400, 0, 4'h0);      chk("unmapped", 16'(last_rd), 16'h0);

        // GPIO
        cyc(BASE, 1, 4'h5);
        cyc(BASE + 12'd1, 1, 4'hC);
        tb_gin = 8'h3E;
        cyc(BASE + 12'd2, 0, 4'h0); chk("gpio_out_c5", 16'(last_gpio), 16'hC5);
        cyc(BASE + 12'd2, 0, 4'h0);
        cyc(BASE + 12'd2, 0, 4'h0); chk("gpio_in_l", 16'(last_rd), 16'hE);
        cyc(BASE + 12'd3, 0, 4'h0); chk("gpio_in_h", 16'(last_rd), 16'h3);

        // One-shot timer: compare 5, p 0, en + irq_en
        cyc(BASE + 12'd6, 1, 4'h5);
        cyc(BASE + 12'd7, 1, 4'h0);
        cyc(BASE + 12'd10, 1, 4'h0);
        cyc(BASE + 12'd4, 1, 4'b0101);
        for (int i = 0; i < 6; i++) begin
            cyc(BASE + 12'd5, 0, 4'h0); chk("oneshot_nomatch", 16'(last_rd), 16'h0);
        end
        cyc(BASE + 12'd5, 0, 4'h0); chk("oneshot_match", 16'(last_rd), 16'h1);
        chk("oneshot_irq_lag", 16'(last_irq), 16'h0);
        cyc(BASE + 12'd8, 0, 4'h0); chk("oneshot_cnt", 16'(last_rd), 16'h5);
        chk("oneshot_irq", 16'(last_irq), 16'h1);
        repeat (4) cyc(BASE + 12'd8, 0, 4'h0);
        chk("halt_cnt", 16'(last_rd), 16'h5);
        cyc(BASE + 12'd5, 1, 4'h1);
        cyc(BASE + 12'd5, 0, 4'h0); chk("w1c_irq_hold", 16'(last_irq), 16'h1);
        chk("w1c_stat", 16'(last_rd), 16'h0);
        cyc(BASE + 12'd5, 0, 4'h0); chk("w1c_irq_drop", 16'(last_irq), 16'h0);

        // Reload with prescale: compare 2, p 2
        cyc(BASE + 12'd4, 1, 4'b0000);
        cyc(BASE + 12'd8, 1, 4'h0);
        cyc(BASE + 12'd6, 1, 4'h2);
        cyc(BASE + 12'd10, 1, 4'h2);
        cyc(BASE + 12'd4, 1, 4'b0011);
        for (int i = 0; i < 40; i++) begin
            cyc(BASE + 12'd5, 1, 4'h1);
            if (last_rd == 4'h1) hits.push_back(i);
        end
        chk("reload_hits", 16'(hits.size() >= 2), 16'h1);
        if (hits.size() >= 2) chk("reload_period", 16'(hits[1] - hits[0]), 16'd12);

        // W1C on the exact match edge: set wins
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (m_will_tick() && m_cnt == m_cmp) begin
                cyc(BASE + 12'd5, 1, 4'h1);
                cyc(BASE + 12'd5, 0, 4'h0); chk("w1c_vs_set", 16'(last_rd), 16'h1);
                done = 1;
            end else begin
                cyc(BASE + 12'd5, 0, 4'h0);
            end
        end
        chk("w1c_vs_set_found", 16'(done), 16'h1);

        // Count write on a tick edge: write wins
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (m_will_tick() && m_cnt != m_cmp) begin
                cyc(BASE + 12'd9, 1, 4'h7);
                cyc(BASE + 12'd8, 0, 4'h0); chk("cntwr_vs_tick", 16'(last_rd), 16'h0);
                done = 1;
            end else begin
                cyc(BASE + 12'd8, 0, 4'h0);
            end
        end
        chk("cntwr_vs_tick_found", 16'(done), 16'h1);

        // Asynchronous reset while running with irq asserted
        cyc(BASE + 12'd4, 1, 4'b0111);
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            cyc(BASE + 12'd8, 0, 4'h0);
            if (last_irq && m_cnt != 8'h00) done = 1;
        end
        chk("arst_setup", 16'(done), 16'h1);
        @(negedge clk);
        bus_addr = BASE + 12'd8; bus_data_rw = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt", 16'(bus_data_out), 16'h0);
        chk("arst_irq", 16'(irq), 16'h0);
        chk("arst_gpio", 16'(gpio_out), 16'h0);
        bus_addr = BASE + 12'd4;
        #0.5;
        chk("arst_ctrl", 16'(bus_data_out), 16'h0);
        m_reset();
        tb_gin = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        cyc(12'h003, 0, 4'h0); chk("arst_ram", 16'(last_rd), 16'h0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            int sel;
            if ($urandom_range(0, 19) == 0) tb_gin = 8'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel < 4)       a = 12'($urandom_range(0, 15));
            else if (sel == 4) a = 12'($urandom);
            else               a = BASE + 12'($urandom_range(0, 15));
            rw = ($urandom_range(0, 2) == 0);
            d  = 4'($urandom);
            if (a == BASE + 12'd10) d = 4'($urandom_range(0, 2));
            cyc(a, rw, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
